// File: rtl/ddr3_write_burst_tx_pkg.sv
// Shared constants and FSM encodings for the DDR3 write-burst transmitter.
// Optional data-mask support is enabled by defining DDR3_TX_DM_EN.
package ddr3_write_burst_tx_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_BL = 8;
  localparam int unsigned DEF_WL = 5;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_PRE   = 3'd2;
  localparam logic [2:0] S_BURST = 3'd3;
  localparam logic [2:0] S_POST  = 3'd4;

  // Beat-counter width: clog2(BL), never narrower than one bit.
  function automatic int unsigned beat_cnt_w(input int unsigned bl);
    return (bl > 2) ? $clog2(bl) : 1;
  endfunction

endpackage

// File: rtl/ddr3_tx_serializer.sv
// Burst serializer: loads a full burst, emits one DW beat per shift cycle and the DQS toggle.
// With DDR3_TX_DM_EN defined it also carries the per-beat data mask.
module ddr3_tx_serializer #(
  parameter int unsigned DW = 16,
  parameter int unsigned BL = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DW*BL-1:0] i_wdata,
`ifdef DDR3_TX_DM_EN
  input  logic [BL-1:0]    i_wmask,
  output logic             o_dm,
`endif
  input  logic             i_shift,
  output logic [DW-1:0]    o_dq,
  output logic             o_dqs
);

  logic [DW*BL-1:0] r_data;
  logic             r_phase;
  logic [DW-1:0]    r_dq;
  logic             r_dqs;
`ifdef DDR3_TX_DM_EN
  logic [BL-1:0]    r_mask;
  logic             r_dm;
`endif

  // r_phase starts high so beat 0 goes out on a DQS rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_phase <= 1'b1;
      r_dq    <= '0;
      r_dqs   <= 1'b0;
`ifdef DDR3_TX_DM_EN
      r_mask  <= '0;
      r_dm    <= 1'b0;
`endif
    end else begin
      if (i_load) begin
        r_data  <= i_wdata;
        r_phase <= 1'b1;
`ifdef DDR3_TX_DM_EN
        r_mask  <= i_wmask;
`endif
      end else if (i_shift) begin
        r_data  <= r_data >> DW;
        r_phase <= ~r_phase;
`ifdef DDR3_TX_DM_EN
        r_mask  <= r_mask >> 1;
`endif
      end
      r_dq  <= i_shift ? r_data[DW-1:0] : '0;
      r_dqs <= i_shift & r_phase;
`ifdef DDR3_TX_DM_EN
      r_dm  <= i_shift & r_mask[0];
`endif
    end
  end

  assign o_dq  = r_dq;
  assign o_dqs = r_dqs;
`ifdef DDR3_TX_DM_EN
  assign o_dm  = r_dm;
`endif

endmodule

// File: rtl/ddr3_write_burst_tx.sv
// DDR3 write-path transmitter: FSM and write-latency counter driving DQ/DQS for one burst.
// Define DDR3_TX_DM_EN to add the wmask input and dm_out output.
module ddr3_write_burst_tx
  import ddr3_write_burst_tx_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned BL = DEF_BL,
  parameter int unsigned WL = DEF_WL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW*BL-1:0] wdata,
`ifdef DDR3_TX_DM_EN
  input  logic [BL-1:0]    wmask,
  output logic             dm_out,
`endif
  output logic             ready,
  output logic             busy,
  output logic [DW-1:0]    dq_out,
  output logic             dq_oe,
  output logic             dqs_out,
  output logic             dqs_oe,
  output logic             done
);

  localparam int unsigned BEAT_W = beat_cnt_w(BL);
  localparam int unsigned LAT_W  = 4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_d;
  logic [LAT_W-1:0]  r_lat;
  logic [BEAT_W-1:0] r_beat;
  logic              w_accept;
  logic              w_last_wait;
  logic              w_last_beat;
  logic              r_ready;
  logic              r_busy;
  logic              r_dq_oe;
  logic              r_dqs_oe;
  logic              r_done;

  assign w_accept    = start && (r_state == S_IDLE);
  assign w_last_wait = (r_lat == LAT_W'(WL - 1));
  assign w_last_beat = (r_beat == BEAT_W'(BL - 1));

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_d = (WL == 1) ? S_PRE : S_WAIT;
      S_WAIT:  if (w_last_wait) w_state_d = S_PRE;
      S_PRE:   w_state_d = S_BURST;
      S_BURST: if (w_last_beat) w_state_d = S_POST;
      S_POST:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  // r_lat counts WAIT cycles starting at 1, so WAIT ends after WL-1 cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_lat <= LAT_W'(1);
      end else if (r_state == S_WAIT) begin
        r_lat <= r_lat + 1'b1;
      end else begin
        r_lat <= '0;
      end
      if ((r_state == S_BURST) && !w_last_beat) begin
        r_beat <= r_beat + 1'b1;
      end else begin
        r_beat <= '0;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_dq_oe  <= 1'b0;
      r_dqs_oe <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ready  <= (w_state_d == S_IDLE);
      r_busy   <= (w_state_d != S_IDLE);
      r_dq_oe  <= (w_state_d == S_BURST);
      r_dqs_oe <= (w_state_d == S_PRE) || (w_state_d == S_BURST) || (w_state_d == S_POST);
      r_done   <= (w_state_d == S_POST);
    end
  end

  ddr3_tx_serializer #(
    .DW (DW),
    .BL (BL)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_wdata (wdata),
`ifdef DDR3_TX_DM_EN
    .i_wmask (wmask),
    .o_dm    (dm_out),
`endif
    .i_shift (w_state_d == S_BURST),
    .o_dq    (dq_out),
    .o_dqs   (dqs_out)
  );

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign dq_oe  = r_dq_oe;
  assign dqs_oe = r_dqs_oe;
  assign done   = r_done;

endmodule

// File: tb/tb_ddr3_write_burst_tx.sv
// Directed bench for ddr3_write_burst_tx: WL=5 vector table plus a WL=1 hand sequence.
// Checks dm_out as well when DDR3_TX_DM_EN is defined.
module tb_ddr3_write_burst_tx;

  localparam int unsigned DW = 16;
  localparam int unsigned BL = 8;

  // Expected-flag layout: {ready, busy, dq_oe, dqs_oe, dqs_out, done, dm_out}
  localparam logic [6:0] F_IDLE = 7'b1000000;
  localparam logic [6:0] F_WAIT = 7'b0100000;
  localparam logic [6:0] F_PRE  = 7'b0101000;
  localparam logic [6:0] F_POST = 7'b0101010;
`ifdef DDR3_TX_DM_EN
  localparam logic [22:0] CMP_MASK = 23'h7fffff;
`else
  localparam logic [22:0] CMP_MASK = 23'h7effff;
`endif

  typedef struct {
    logic        rst;
    logic        start;
    logic        sel_b;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs [0:32];

  logic             clk = 1'b0;
  logic             reset;
  logic             start5;
  logic             start1;
  logic [DW*BL-1:0] wdata;
  logic [DW*BL-1:0] data_a;
  logic [DW*BL-1:0] data_b;
  logic [BL-1:0]    wmask;
  logic [BL-1:0]    mask_a;
  logic [BL-1:0]    mask_b;

  logic          ready5, busy5, dq_oe5, dqs5, dqs_oe5, done5, dm5;
  logic [DW-1:0] dq5;
  logic          ready1, busy1, dq_oe1, dqs1, dqs_oe1, done1, dm1;
  logic [DW-1:0] dq1;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  ddr3_write_burst_tx #(.DW(DW), .BL(BL), .WL(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start5),
    .wdata   (wdata),
`ifdef DDR3_TX_DM_EN
    .wmask   (wmask),
    .dm_out  (dm5),
`endif
    .ready   (ready5),
    .busy    (busy5),
    .dq_out  (dq5),
    .dq_oe   (dq_oe5),
    .dqs_out (dqs5),
    .dqs_oe  (dqs_oe5),
    .done    (done5)
  );

  ddr3_write_burst_tx #(.DW(DW), .BL(BL), .WL(1)) dut_wl1 (
    .clk     (clk),
    .reset   (reset),
    .start   (start1),
    .wdata   (wdata),
`ifdef DDR3_TX_DM_EN
    .wmask   (wmask),
    .dm_out  (dm1),
`endif
    .ready   (ready1),
    .busy    (busy1),
    .dq_out  (dq1),
    .dq_oe   (dq_oe1),
    .dqs_out (dqs1),
    .dqs_oe  (dqs_oe1),
    .done    (done1)
  );

`ifndef DDR3_TX_DM_EN
  assign dm5 = 1'b0;
  assign dm1 = 1'b0;
`endif

  function automatic logic [6:0] fb(input logic dqs, input logic dm);
    return {4'b0111, dqs, 1'b0, dm};
  endfunction

  task automatic put(input int n, input logic rst, input logic st, input logic sb,
                     input logic [6:0] flags, input logic [15:0] dq);
    vecs[n].rst   = rst;
    vecs[n].start = st;
    vecs[n].sel_b = sb;
    vecs[n].exp   = {flags, dq};
  endtask

  task automatic check(input string name, input int idx, input logic [22:0] got,
                       input logic [22:0] exp);
    vec_cnt++;
    if ((got & CMP_MASK) !== (exp & CMP_MASK)) begin
      miss_cnt++;
      $display("FAIL %s[%0d]: got {rdy,busy,dqoe,dqsoe,dqs,done,dm,dq}=%b_%h expected %b_%h",
               name, idx, got[22:16], got[15:0], exp[22:16], exp[15:0]);
    end
  endtask

  task automatic drive_data(input logic sb);
    wdata = sb ? data_b : data_a;
    wmask = sb ? mask_b : mask_a;
  endtask

  initial begin
    logic [22:0] exp1;

    for (int i = 0; i < BL; i++) begin
      data_a[DW*i +: DW] = 16'h1000 + 16'(i);
      data_b[DW*i +: DW] = 16'hb000 + 16'(i);
    end
    mask_a = 8'b1010_0101;
    mask_b = 8'b0000_1111;

    // WL=5: burst, ignored start at 3, back-to-back at 15, reset at 23, reset+start at 24.
    put(0, 0, 1, 0, F_IDLE, 16'h0000);
    put(1, 0, 0, 1, F_WAIT, 16'h0000);
    put(2, 0, 0, 1, F_WAIT, 16'h0000);
    put(3, 0, 1, 1, F_WAIT, 16'h0000);
    put(4, 0, 0, 1, F_WAIT, 16'h0000);
    put(5, 0, 0, 1, F_PRE,  16'h0000);
    for (int j = 0; j < 8; j++) begin
      put(6 + j, 0, 0, 1, fb(j % 2 == 0, mask_a[j]), 16'h1000 + 16'(j));
    end
    put(14, 0, 0, 1, F_POST, 16'h0000);
    put(15, 0, 1, 1, F_IDLE, 16'h0000);
    put(16, 0, 0, 0, F_WAIT, 16'h0000);
    put(17, 0, 0, 0, F_WAIT, 16'h0000);
    put(18, 0, 0, 0, F_WAIT, 16'h0000);
    put(19, 0, 0, 0, F_WAIT, 16'h0000);
    put(20, 0, 0, 0, F_PRE,  16'h0000);
    put(21, 0, 0, 0, fb(1, mask_b[0]), 16'hb000);
    put(22, 0, 0, 0, fb(0, mask_b[1]), 16'hb001);
    put(23, 1, 0, 0, fb(1, mask_b[2]), 16'hb002);
    put(24, 1, 1, 1, F_IDLE, 16'h0000);
    put(25, 0, 1, 0, F_IDLE, 16'h0000);
    put(26, 0, 0, 1, F_WAIT, 16'h0000);
    put(27, 0, 0, 1, F_WAIT, 16'h0000);
    put(28, 0, 0, 1, F_WAIT, 16'h0000);
    put(29, 0, 0, 1, F_WAIT, 16'h0000);
    put(30, 0, 0, 1, F_PRE,  16'h0000);
    put(31, 0, 0, 1, fb(1, mask_a[0]), 16'h1000);
    put(32, 0, 0, 1, fb(0, mask_a[1]), 16'h1001);

    reset  = 1'b1;
    start5 = 1'b0;
    start1 = 1'b0;
    drive_data(1'b0);
    repeat (3) @(negedge clk);

    for (int n = 0; n <= 32; n++) begin
      if (n > 0) @(negedge clk);
      check("wl5", n, {ready5, busy5, dq_oe5, dqs_oe5, dqs5, done5, dm5, dq5}, vecs[n].exp);
      reset  = vecs[n].rst;
      start5 = vecs[n].start;
      drive_data(vecs[n].sel_b);
    end

    // WL=1: no WAIT, preamble at cycle 1, beats 2..9, postamble 10, idle 11.
    start5 = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive_data(1'b0);
    for (int n = 0; n <= 11; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0 || n == 11) exp1 = {F_IDLE, 16'h0000};
      else if (n == 1)       exp1 = {F_PRE, 16'h0000};
      else if (n == 10)      exp1 = {F_POST, 16'h0000};
      else                   exp1 = {fb(n % 2 == 0, mask_a[n-2]), 16'h1000 + 16'(n - 2)};
      check("wl1", n, {ready1, busy1, dq_oe1, dqs_oe1, dqs1, done1, dm1, dq1}, exp1);
      start1 = (n == 0);
      if (n > 0) drive_data(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
